// File: rtl/aes_inv_round_seq.sv
// aes_inv_round_seq: iterative AES inverse-cipher controller and state register.
// Accepts a ciphertext block and applies the initial AddRoundKey. It then clocks
// round_result from the external inverse-round datapath into state_q for NR
// cycles while walking rk_idx from NR-1 down to 0. The plaintext is presented
// on a valid/ready output.
// Optional build macro AES_STATE_SCRUB_EN: clears state_q on the output
// handshake so no plaintext residue stays on the datapath while idle.
module aes_inv_round_seq #(
    parameter int unsigned NR  = 10,
    parameter int unsigned RKW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   data_in,
    output logic [RKW-1:0] rk_idx,
    input  logic [127:0]   round_key,
    output logic [127:0]   state_q,
    output logic           last_round,
    input  logic [127:0]   round_result,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   data_out
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_inv_round_seq: NR must be 10, 12 or 14");
    end
    if ((2 ** RKW) <= NR) begin : g_bad_rkw
        $error("aes_inv_round_seq: RKW too narrow to index round key NR");
    end

    localparam logic [RKW-1:0] RkTop   = RKW'(NR);
    localparam logic [RKW-1:0] RkFirst = RKW'(NR - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StDone
    } st_e;

    st_e            st_q, st_d;
    logic [RKW-1:0] rk_q, rk_d;
    logic [127:0]   state_d;

    assign rk_idx   = rk_q;
    assign data_out = state_q;

    // Next-state, key index and state-register load selection.
    always_comb begin
        st_d       = st_q;
        rk_d       = rk_q;
        state_d    = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        last_round = 1'b0;
        unique case (st_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // round_key is the final round key here since rk_idx == NR
                    state_d = data_in ^ round_key;
                    rk_d    = RkFirst;
                    st_d    = StRound;
                end
            end
            StRound: begin
                last_round = (rk_q == '0);
                state_d    = round_result;
                if (rk_q == '0) begin
                    st_d = StDone;
                end else begin
                    rk_d = rk_q - RKW'(1);
                end
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    rk_d = RkTop;
                    st_d = StIdle;
`ifdef AES_STATE_SCRUB_EN
                    state_d = '0;
`else
                    state_d = state_q;
`endif
                end
            end
            default: begin
                st_d = StIdle;
                rk_d = RkTop;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= StIdle;
            rk_q    <= RkTop;
            state_q <= '0;
        end else begin
            st_q    <= st_d;
            rk_q    <= rk_d;
            state_q <= state_d;
        end
    end

endmodule
